booth_mult_unit: RTL and testbench

//   Sequential radix-2 Booth multiplier for MULT. Feeds the HI/LO registers of the multicycle CPU.
//   The control unit pulses start with operands taken from the A/B registers.
//   It waits for done, then asserts high_write/low_write to capture hi/lo.

---
 rtl/mult_div_pkg.sv | 15 +
 rtl/booth_step.sv | 39 +++
 rtl/booth_mult_unit.sv | 181 ++++++++++++++++++
 tb/tb_booth_mult_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the mult/div result path (multiplier and divider).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_div_pkg;

    // Operand width shared by the multiplier and the divider.
    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract M into the upper half, then
// arithmetic-shift {upper, lower, q_1} right by one bit.
// Latency: combinational. Backpressure: none (pure function).
//
// Ports:
//   upper      accumulator (WIDTH+1 bits, two's complement)
//   lower      multiplier / low product bits (LOWER_W bits)
//   q_1        previously examined multiplier bit
//   m          multiplicand, already extended to WIDTH+1 bits
//   *_next     register contents after this iteration
module booth_step #(
    parameter int WIDTH   = 32,
    parameter int LOWER_W = 32
) (
    input  logic [WIDTH:0]   upper,
    input  logic [LOWER_W-1:0] lower,
    input  logic             q_1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   upper_next,
    output logic [LOWER_W-1:0] lower_next,
    output logic             q_1_next
);

    logic [WIDTH:0] acc;

    always_comb begin
        acc = upper;
        case ({lower[0], q_1})
            2'b01:   acc = upper + m;
            2'b10:   acc = upper - m;
            default: acc = upper;
        endcase
        // Arithmetic shift of the whole {acc, lower, q_1} chain.
        upper_next = {acc[WIDTH], acc[WIDTH:1]};
        lower_next = {acc[0], lower[LOWER_W-1:1]};
        q_1_next   = lower[0];
    end

endmodule

// File: rtl/booth_mult_unit.sv
// Sequential radix-2 Booth multiplier feeding the HI/LO registers (MULT, optional MULTU).
// Latency: start at edge k -> done pulse and hi/lo update at edge k+WIDTH+1 (k+WIDTH+2 for MULTU).
// Backpressure: none; start is only accepted in IDLE, starts while busy are dropped, not queued.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   start        one-cycle request, sampled in IDLE only
//   unsigned_op  (MULT_UNSIGNED_EN builds only) 1 = unsigned product, sampled with start
//   a, b         multiplicand / multiplier
//   hi, lo       registered upper / lower halves of the product; hold until next completion
//   busy         high while an operation is in RUN or DONE
//   done         one-cycle pulse coincident with the hi/lo update
//
// Build option: define MULT_UNSIGNED_EN to add the unsigned_op port and MULTU support.
module booth_mult_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
`ifdef MULT_UNSIGNED_EN
    input  logic             unsigned_op,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    // Unsigned operation needs one extra multiplier bit (the zero sign) and one
    // extra iteration, so the low register grows by one bit in that build.
`ifdef MULT_UNSIGNED_EN
    localparam int LW = WIDTH + 1;
`else
    localparam int LW = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);

    localparam logic [CW-1:0] LAST_SIGNED   = CW'(WIDTH - 1);
`ifdef MULT_UNSIGNED_EN
    localparam logic [CW-1:0] LAST_UNSIGNED = CW'(WIDTH);
`endif

    mult_state_t state_q, state_d;

    logic [WIDTH:0]   m_q;
    logic [WIDTH:0]   upper_q;
    logic [LW-1:0]    lower_q;
    logic             q1_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;
`ifdef MULT_UNSIGNED_EN
    logic             uns_q;
`endif

    logic [WIDTH:0]   step_upper;
    logic [LW-1:0]    step_lower;
    logic             step_q1;

    logic [WIDTH:0]   m_load;
    logic [LW-1:0]    lower_load;
    logic             last_iter;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;

    // Top accumulator bit is only a guard bit; the product never needs it.
    logic             unused_guard;
    assign unused_guard = upper_q[WIDTH];

    booth_step #(
        .WIDTH   (WIDTH),
        .LOWER_W (LW)
    ) u_step (
        .upper      (upper_q),
        .lower      (lower_q),
        .q_1        (q1_q),
        .m          (m_q),
        .upper_next (step_upper),
        .lower_next (step_lower),
        .q_1_next   (step_q1)
    );

    // Operand extension and product alignment.
    always_comb begin
`ifdef MULT_UNSIGNED_EN
        m_load     = {a[WIDTH-1] & ~unsigned_op, a};
        lower_load = {b[WIDTH-1] & ~unsigned_op, b};
        last_iter  = (count_q == (uns_q ? LAST_UNSIGNED : LAST_SIGNED));
        if (uns_q) begin
            // WIDTH+1 shifts: product occupies {upper, lower} fully.
            prod_hi = {upper_q[WIDTH-2:0], lower_q[WIDTH]};
            prod_lo = lower_q[WIDTH-1:0];
        end else begin
            // WIDTH shifts: the extension bit of b is left in lower[0].
            prod_hi = upper_q[WIDTH-1:0];
            prod_lo = lower_q[WIDTH:1];
        end
`else
        m_load     = {a[WIDTH-1], a};
        lower_load = b;
        last_iter  = (count_q == LAST_SIGNED);
        prod_hi    = upper_q[WIDTH-1:0];
        prod_lo    = lower_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_q     <= '0;
            upper_q <= '0;
            lower_q <= '0;
            q1_q    <= 1'b0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifdef MULT_UNSIGNED_EN
            uns_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q     <= m_load;
                        upper_q <= '0;
                        lower_q <= lower_load;
                        q1_q    <= 1'b0;
                        count_q <= '0;
`ifdef MULT_UNSIGNED_EN
                        uns_q   <= unsigned_op;
`endif
                    end
                end
                RUN: begin
                    upper_q <= step_upper;
                    lower_q <= step_lower;
                    q1_q    <= step_q1;
                    count_q <= count_q + 1'b1;
                end
                DONE: begin
                    hi_q   <= prod_hi;
                    lo_q   <= prod_lo;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_booth_mult_unit.sv
// Directed bench for booth_mult_unit: reset values, signed products, extreme
// operands, hold behaviour, busy filtering, mid-run reset, back-to-back ops.
// Builds with or without MULT_UNSIGNED_EN.
module tb_booth_mult_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
`ifdef MULT_UNSIGNED_EN
    logic        uns_op = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    booth_mult_unit #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
`ifdef MULT_UNSIGNED_EN
        .unsigned_op (uns_op),
`endif
        .a           (a),
        .b           (b),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    // Drive a one-cycle start; returns 1ns after the sampling edge (edge k).
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
        @(negedge clock);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Count edges after edge k until done is seen (bounded).
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clock);
            #1;
            cyc++;
        end while (!done && cyc < 100);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_signed_vectors;
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic [31:0] eh [6];
        logic [31:0] el [6];
        int cyc;
        va[0] = 32'h0000_0007; vb[0] = 32'hFFFF_FFFD; eh[0] = 32'hFFFF_FFFF; el[0] = 32'hFFFF_FFEB;
        va[1] = 32'h8000_0000; vb[1] = 32'h8000_0000; eh[1] = 32'h4000_0000; el[1] = 32'h0000_0000;
        va[2] = 32'h7FFF_FFFF; vb[2] = 32'h7FFF_FFFF; eh[2] = 32'h3FFF_FFFF; el[2] = 32'h0000_0001;
        va[3] = 32'h8000_0000; vb[3] = 32'h7FFF_FFFF; eh[3] = 32'hC000_0000; el[3] = 32'h8000_0000;
        va[4] = 32'hFFFF_FFFB; vb[4] = 32'h0000_0009; eh[4] = 32'hFFFF_FFFF; el[4] = 32'hFFFF_FFD3;
        va[5] = 32'h1234_5678; vb[5] = 32'h0000_0010; eh[5] = 32'h0000_0001; el[5] = 32'h2345_6780;
        for (int i = 0; i < 6; i++) begin
            start_op(va[i], vb[i]);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL vec%0d_busy got %b want 1", i, busy); end
            wait_done(cyc);
            checks++; if (cyc != 33)   begin errors++; $display("FAIL vec%0d_latency got %0d want 33", i, cyc); end
            checks++; if (hi !== eh[i]) begin errors++; $display("FAIL vec%0d_hi got %h want %h", i, hi, eh[i]); end
            checks++; if (lo !== el[i]) begin errors++; $display("FAIL vec%0d_lo got %h want %h", i, lo, el[i]); end
            if (i == 0) begin
                @(posedge clock);
                #1;
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", done); end
            end
        end
    endtask

    task automatic test_hold;
        int cyc;
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc);
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL neg1sq_hi got %h want 0", hi); end
        checks++; if (lo !== 32'h1) begin errors++; $display("FAIL neg1sq_lo got %h want 1", lo); end
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        repeat (10) @(posedge clock);
        #1;
        checks++; if (hi !== 32'h0 || lo !== 32'h1) begin errors++; $display("FAIL hold_idle got %h_%h want 0_1", hi, lo); end
        start_op(32'h0, 32'h5);
        repeat (20) @(posedge clock);
        #1;
        checks++; if (hi !== 32'h0 || lo !== 32'h1) begin errors++; $display("FAIL hold_run got %h_%h want 0_1", hi, lo); end
        wait_done(cyc);
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL zero_prod got %h_%h want 0_0", hi, lo); end
    endtask

    task automatic test_busy_filter;
        int ndone = 0;
        int first = 0;
        start_op(32'd6, 32'd7);
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(posedge clock);
            #1;
            if (done) begin
                ndone++;
                if (first == 0) first = cyc;
            end
            if (cyc == 5) begin
                a = 32'd100;
                b = 32'd100;
            end
            if (cyc == 10) begin
                start = 1'b1; a = 32'd1; b = 32'd1;
            end
            if (cyc == 11) start = 1'b0;
            if (cyc == 32) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL done_state_busy got %b want 1", busy); end
                start = 1'b1; a = 32'd1; b = 32'd1;
            end
            if (cyc == 33) begin
                start = 1'b0;
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_fall got %b want 0", busy); end
            end
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL filter_done_count got %0d want 1", ndone); end
        checks++; if (first != 33) begin errors++; $display("FAIL filter_done_cycle got %0d want 33", first); end
        checks++; if (hi !== 32'h0 || lo !== 32'd42) begin errors++; $display("FAIL filter_result got %h_%h want 0_2a", hi, lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL filter_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid;
        int ndone = 0;
        int cyc;
        start_op(32'd9, 32'd9);
        repeat (15) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL midrst_hilo got %h_%h want 0_0", hi, lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL midrst_spurious_done got %0d want 0", ndone); end
        start_op(32'h0000_0007, 32'hFFFF_FFFD);
        wait_done(cyc);
        checks++; if (cyc != 33) begin errors++; $display("FAIL after_rst_latency got %0d want 33", cyc); end
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL after_rst_result got %h_%h want ffffffff_ffffffeb", hi, lo); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        start_op(32'd3, 32'd5);
        wait_done(cyc);
        start_op(32'hFFFF_FFFE, 32'hFFFF_FFFE);
        wait_done(cyc);
        checks++; if (cyc != 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", cyc); end
        checks++; if (hi !== 32'h0 || lo !== 32'd4) begin errors++; $display("FAIL b2b_result got %h_%h want 0_4", hi, lo); end
    endtask

`ifdef MULT_UNSIGNED_EN
    task automatic test_unsigned;
        int cyc;
        uns_op = 1'b1;
        start_op(32'hFFFF_FFFF, 32'h2);
        uns_op = 1'b0;
        wait_done(cyc);
        checks++; if (cyc != 34) begin errors++; $display("FAIL u_latency got %0d want 34", cyc); end
        checks++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL u_result got %h_%h want 1_fffffffe", hi, lo); end
        uns_op = 1'b1;
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        uns_op = 1'b0;
        wait_done(cyc);
        checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin errors++; $display("FAIL u_max got %h_%h want fffffffe_1", hi, lo); end
        uns_op = 1'b0;
        start_op(32'hFFFF_FFFF, 32'h2);
        wait_done(cyc);
        checks++; if (cyc != 33) begin errors++; $display("FAIL s_latency got %0d want 33", cyc); end
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL s_result got %h_%h want ffffffff_fffffffe", hi, lo); end
    endtask
`endif

    initial begin
        test_reset();
        test_signed_vectors();
        test_hold();
        test_busy_filter();
        test_reset_mid();
        test_back_to_back();
`ifdef MULT_UNSIGNED_EN
        test_unsigned();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
